// File: rtl/winograd_tile_buffer_if.sv
// Handshake bundle for the Winograd tile buffer: raster pixel stream in,
// 4x4 tile stream out, plus the per-tile `next` and end-of-frame pulses.
interface winograd_tile_buffer_if #(
  parameter int DATA_W = 32
);
  // Pixel stream (upstream -> tile buffer)
  logic [DATA_W-1:0]             in_data;
  logic                          in_valid;
  logic                          in_ready;
  // Tile stream (tile buffer -> processing element)
  logic [0:3][0:3][DATA_W-1:0]   tile_out;
  logic                          tile_valid;
  logic                          tile_ready;
  logic                          next;
  logic                          frame_done;

  // Tile buffer side
  modport master (
    input  in_data, in_valid, tile_ready,
    output in_ready, tile_out, tile_valid, next, frame_done
  );

  // Pixel source / tile consumer side
  modport slave (
    output in_data, in_valid, tile_ready,
    input  in_ready, tile_out, tile_valid, next, frame_done
  );
endinterface

// File: rtl/winograd_tile_buffer.sv
// Winograd F(2x2,3x3) input-tile assembler. A raster pixel stream is kept in
// four circular line buffers; a 4x4 column window slides along the current
// row and is copied to the output register whenever the window covers a
// stride-2 tile position. Output holds until the consumer accepts it.
module winograd_tile_buffer #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,   // asynchronous, active low
  winograd_tile_buffer_if.master bus
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  typedef logic [DATA_W-1:0]             pix_t;
  typedef logic [0:3][0:3][DATA_W-1:0]   win_t;

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  win_t             win_q, win_d;
  win_t             tile_q, tile_d;
  logic             tile_valid_q, tile_valid_d;
  logic             last_q, last_d;

  logic             in_ready_int;
  logic             accept;
  logic             tile_take;
  logic             tile_pos;
  logic             load;
  pix_t             rd_data [4];

  // Line buffers, one per row mod 4. The read port is registered and
  // addressed with the column the window will need at the next accept, so
  // the data is already waiting when that pixel arrives. The write always
  // targets the current column, which never equals the look-ahead column
  // on an accepting edge, so no read/write collision can occur.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bank
      pix_t mem [IMG_W];
      pix_t rd_q;

      // Bank write on accepted pixels of matching row, look-ahead read
      always_ff @(posedge clk) begin
        if (accept && (row_q[1:0] == 2'(gi))) begin
          mem[col_q] <= bus.in_data;
        end
        rd_q <= mem[col_d];
      end

      assign rd_data[gi] = rd_q;
    end
  endgenerate

  // Handshake, raster counters, window shift and tile load decision
  always_comb begin
    // Held low during reset so nothing is accepted before the counters are valid
    in_ready_int = reset & (~tile_valid_q | bus.tile_ready);
    accept       = bus.in_valid & in_ready_int;
    tile_take    = tile_valid_q & bus.tile_ready;

    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end

    // Window shifts left; the new right column is rows row-3..row, where
    // row-3+k mod 4 is the same bank as row+1+k mod 4.
    win_d = win_q;
    if (accept) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_d[i][j] = win_q[i][j+1];
        end
      end
      for (int k = 0; k < 3; k++) begin
        win_d[k][3] = rd_data[2'(row_q[1:0] + 2'(k + 1))];
      end
      win_d[3][3] = bus.in_data;
    end

    // Tile completes on odd row/col at least 3 (stride 2, 4x4 footprint)
    tile_pos = (row_q >= ROW_W'(3)) & row_q[0] & (col_q >= COL_W'(3)) & col_q[0];
    load     = accept & tile_pos;

    tile_d       = load ? win_d : tile_q;
    tile_valid_d = load | (tile_valid_q & ~bus.tile_ready);
    last_d       = load ? ((row_q == ROW_LAST) && (col_q == COL_LAST)) : last_q;
  end

  // State registers, cleared immediately by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      tile_q       <= '0;
      tile_valid_q <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      tile_q       <= tile_d;
      tile_valid_q <= tile_valid_d;
      last_q       <= last_d;
    end
  end

  assign bus.in_ready   = in_ready_int;
  assign bus.tile_out   = tile_q;
  assign bus.tile_valid = tile_valid_q;
  assign bus.next       = tile_take;
  assign bus.frame_done = tile_take & last_q;

endmodule
